ti_ray_sched: RTL

- Shares one traversal & intersection (T&I) unit among NUM_REQS requesters (per-core ray issue ports).
- Accepts ray requests, grants them round-robin, sequences the unit through issue, busy and done, and routes the result back to the requester that owns it.
- Exactly one ray is outstanding in the T&I unit at a time. Sits between the per-core ray issue logic and the T&I unit.

---
 rtl/ti_ray_sched_pkg.sv | 33 +++
 rtl/ti_rr_arbiter.sv | 52 +++++
 rtl/ti_ray_sched.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ti_ray_sched_pkg.sv
// Shared types and defaults for the T&I ray scheduler.
package ti_ray_sched_pkg;

  localparam int unsigned TI_SCHED_NUM_REQS = 4;
  localparam int unsigned TI_SCHED_TAG_BITS = 8;
  localparam int unsigned TI_RAY_BITS       = 192;
  localparam int unsigned TI_RESULT_BITS    = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } ti_sched_state_t;

  typedef struct packed {
    logic [31:0] org_x;
    logic [31:0] org_y;
    logic [31:0] org_z;
    logic [31:0] dir_x;
    logic [31:0] dir_y;
    logic [31:0] dir_z;
  } ti_ray_t;

  typedef struct packed {
    logic        hit;
    logic [30:0] tri_idx;
    logic [31:0] distance;
    logic [31:0] u;
    logic [31:0] v;
  } ti_result_t;

endpackage

// File: rtl/ti_rr_arbiter.sv
// Round-robin arbiter: first valid requester at or after the pointer wins;
// the pointer moves past the winner only when the grant is accepted.
module ti_rr_arbiter
  import ti_ray_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQS = TI_SCHED_NUM_REQS,
  localparam int unsigned IDX_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] valid,
  input  logic                en,
  input  logic                accept,
  output logic [NUM_REQS-1:0] grant_c,
  output logic [IDX_W-1:0]    grant_idx_c,
  output logic                grant_vld_c
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned idx;
    logic        found;
    idx         = 0;
    found       = 1'b0;
    grant_idx_c = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_REQS) idx = idx - NUM_REQS;
      if (!found && valid[IDX_W'(idx)]) begin
        found       = 1'b1;
        grant_idx_c = IDX_W'(idx);
      end
    end
    grant_vld_c = en && found;
    grant_c     = '0;
    if (grant_vld_c) grant_c[grant_idx_c] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (grant_idx_c == IDX_W'(NUM_REQS - 1)) ? '0 : grant_idx_c + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ti_ray_sched.sv
// Shares one T&I unit among NUM_REQS ray issuers, one ray in flight at a time.
// Optional performance counters are built when TI_SCHED_PERF_EN is defined.
module ti_ray_sched
  import ti_ray_sched_pkg::*;
#(
  parameter int unsigned NUM_REQS    = TI_SCHED_NUM_REQS,
  parameter int unsigned RAY_BITS    = TI_RAY_BITS,
  parameter int unsigned RESULT_BITS = TI_RESULT_BITS,
  parameter int unsigned TAG_BITS    = TI_SCHED_TAG_BITS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_enable,
  input  logic [NUM_REQS-1:0]          req_valid,
  input  logic [NUM_REQS*RAY_BITS-1:0] req_ray,
  input  logic [NUM_REQS*TAG_BITS-1:0] req_tag,
  output logic [NUM_REQS-1:0]          req_ready,
  output logic [NUM_REQS-1:0]          rsp_valid,
  output logic [RESULT_BITS-1:0]       rsp_result,
  output logic [TAG_BITS-1:0]          rsp_tag,
  input  logic [NUM_REQS-1:0]          rsp_ready,
  output logic                         unit_valid,
  output logic [RAY_BITS-1:0]          unit_ray,
  input  logic                         unit_ready,
  input  logic                         unit_done,
  input  logic [RESULT_BITS-1:0]       unit_result,
  output logic                         sched_busy
`ifdef TI_SCHED_PERF_EN
  ,
  output logic [31:0]                  perf_rays,
  output logic [31:0]                  perf_busy_cycles,
  output logic [31:0]                  perf_wait_cycles
`endif
);

  localparam int unsigned IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  ti_sched_state_t         state_q, state_d;
  logic [RAY_BITS-1:0]     ray_q, ray_d;
  logic [TAG_BITS-1:0]     tag_q, tag_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [RESULT_BITS-1:0]  result_q, result_d;
  logic                    unit_valid_q, unit_valid_d;
  logic [NUM_REQS-1:0]     rsp_valid_q, rsp_valid_d;
  logic                    busy_q, busy_d;

  logic                    arb_en_c;
  logic                    accept_c;
  logic [NUM_REQS-1:0]     grant_c;
  logic [IDX_W-1:0]        grant_idx_c;
  logic                    owner_ready_c;

  // Grants are only offered from IDLE, so every grant is accepted.
  assign arb_en_c = cfg_enable && (state_q == IDLE);

  ti_rr_arbiter #(
    .NUM_REQS (NUM_REQS)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .valid       (req_valid),
    .en          (arb_en_c),
    .accept      (accept_c),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c),
    .grant_vld_c (accept_c)
  );

  // The accept strobe is combinational; keep it quiet while reset is held.
  assign req_ready = grant_c & {NUM_REQS{reset}};

  always_comb begin
    owner_ready_c = 1'b0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (owner_q == IDX_W'(i)) owner_ready_c = rsp_ready[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    ray_d    = ray_q;
    tag_d    = tag_q;
    owner_d  = owner_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = ISSUE;
          owner_d = grant_idx_c;
          for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (grant_c[i]) begin
              ray_d = req_ray[i*RAY_BITS +: RAY_BITS];
              tag_d = req_tag[i*TAG_BITS +: TAG_BITS];
            end
          end
        end
      end
      ISSUE: if (unit_ready) state_d = BUSY;
      BUSY: begin
        if (unit_done) begin
          result_d = unit_result;
          state_d  = RESP;
        end
      end
      RESP: if (owner_ready_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs registered from the next state so they change cleanly on edges.
    unit_valid_d = (state_d == ISSUE);
    busy_d       = (state_d != IDLE);
    rsp_valid_d  = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      rsp_valid_d[i] = (state_d == RESP) && (owner_d == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ray_q        <= '0;
      tag_q        <= '0;
      owner_q      <= '0;
      result_q     <= '0;
      unit_valid_q <= 1'b0;
      rsp_valid_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ray_q        <= ray_d;
      tag_q        <= tag_d;
      owner_q      <= owner_d;
      result_q     <= result_d;
      unit_valid_q <= unit_valid_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign unit_valid = unit_valid_q;
  assign unit_ray   = ray_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = result_q;
  assign rsp_tag    = tag_q;
  assign sched_busy = busy_q;

`ifdef TI_SCHED_PERF_EN
  logic [31:0] perf_rays_q, perf_rays_d;
  logic [31:0] perf_busy_q, perf_busy_d;
  logic [31:0] perf_wait_q, perf_wait_d;

  // Free-running counters; they wrap naturally at 2^32.
  always_comb begin
    perf_rays_d = perf_rays_q;
    perf_busy_d = perf_busy_q;
    perf_wait_d = perf_wait_q;
    if (accept_c) perf_rays_d = perf_rays_q + 32'd1;
    if ((state_q == ISSUE) || (state_q == BUSY)) perf_busy_d = perf_busy_q + 32'd1;
    if ((|req_valid) && !accept_c) perf_wait_d = perf_wait_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_rays_q <= '0;
      perf_busy_q <= '0;
      perf_wait_q <= '0;
    end else begin
      perf_rays_q <= perf_rays_d;
      perf_busy_q <= perf_busy_d;
      perf_wait_q <= perf_wait_d;
    end
  end

  assign perf_rays        = perf_rays_q;
  assign perf_busy_cycles = perf_busy_q;
  assign perf_wait_cycles = perf_wait_q;
`endif

endmodule
